// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the XY-routed mesh fabric.
//   - flit header field offsets (destination x/y, packet ID)
//   - router port index constants (Local, N, E, S, W)
//   - canonical 64-bit flit type (valid bit + data)
//   - xy_route(): dimension-ordered output port selection
package noc_pkg;

  localparam int FLIT_W    = 64;

  localparam int DST_X_MSB = 63;
  localparam int DST_X_LSB = 60;
  localparam int DST_Y_MSB = 59;
  localparam int DST_Y_LSB = 56;
  localparam int PID_MSB   = 55;
  localparam int PID_LSB   = 48;

  localparam int NUM_PORTS = 5;

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_N     = 3'd1;
  localparam logic [2:0] P_E     = 3'd2;
  localparam logic [2:0] P_S     = 3'd3;
  localparam logic [2:0] P_W     = 3'd4;

  typedef struct packed {
    logic              valid;
    logic [FLIT_W-1:0] data;
  } flit_t;

  // X is resolved first, then Y; a flit at its destination goes Local.
  function automatic logic [2:0] xy_route(input logic [3:0] own_x,
                                          input logic [3:0] own_y,
                                          input logic [3:0] dst_x,
                                          input logic [3:0] dst_y);
    logic [2:0] port;
    if (dst_x > own_x) begin
      port = P_E;
    end else if (dst_x < own_x) begin
      port = P_W;
    end else if (dst_y > own_y) begin
      port = P_S;
    end else if (dst_y < own_y) begin
      port = P_N;
    end else begin
      port = P_LOCAL;
    end
    return port;
  endfunction

endpackage

// File: rtl/mesh_router.sv
// mesh_router: one node of the XY mesh.
//   Routes each of its 5 inputs (Local, N, E, S, W) by XY order, arbitrates
//   each output with fixed priority Local > W > N > E > S (losers dropped),
//   and registers one data word plus valid bit per output.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid[4:0]         per-input valid, bit index = port constant
//   in_data               5 packed PKTWIDTH words, slice p = port p
//   out_valid[4:0]        registered per-output valid
//   out_data              5 packed registered PKTWIDTH words
module mesh_router
  import noc_pkg::*;
#(
  parameter int PKTWIDTH = 64,
  parameter int X        = 0,
  parameter int Y        = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4:0]                in_valid,
  input  logic [5*PKTWIDTH-1:0]     in_data,
  output logic [4:0]                out_valid,
  output logic [5*PKTWIDTH-1:0]     out_data
);

  localparam logic [3:0] OWN_X = 4'(X);
  localparam logic [3:0] OWN_Y = 4'(Y);

  // Highest priority first.
  localparam logic [2:0] PRIO [5] = '{P_LOCAL, P_W, P_N, P_E, P_S};

  logic [2:0]            in_port    [5];
  logic [4:0]            req        [5];   // req[output][input]
  logic [4:0]            grant_valid;
  logic [2:0]            grant_sel  [5];
  logic [5*PKTWIDTH-1:0] nxt_data;

  // Route compute: requested output port of every input.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      in_port[i] = xy_route(OWN_X, OWN_Y,
                            in_data[i*PKTWIDTH+DST_X_LSB +: 4],
                            in_data[i*PKTWIDTH+DST_Y_LSB +: 4]);
    end
    for (int o = 0; o < 5; o++) begin
      for (int i = 0; i < 5; i++) begin
        req[o][i] = in_valid[i] && (in_port[i] == 3'(o));
      end
    end
  end

  // Fixed-priority arbiter: scan lowest priority first so the highest wins.
  always_comb begin
    for (int o = 0; o < 5; o++) begin
      grant_valid[o] = 1'b0;
      grant_sel[o]   = P_LOCAL;
      for (int k = 4; k >= 0; k--) begin
        if (req[o][PRIO[k]]) begin
          grant_valid[o] = 1'b1;
          grant_sel[o]   = PRIO[k];
        end
      end
    end
  end

  // Output data mux from the granted input.
  always_comb begin
    nxt_data = '0;
    for (int o = 0; o < 5; o++) begin
      nxt_data[o*PKTWIDTH +: PKTWIDTH] = in_data[int'(grant_sel[o])*PKTWIDTH +: PKTWIDTH];
    end
  end

  // Output registers; data is loaded only with a valid flit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 5'b00000;
      out_data  <= '0;
    end else begin
      out_valid <= grant_valid;
      for (int o = 0; o < 5; o++) begin
        if (grant_valid[o]) begin
          out_data[o*PKTWIDTH +: PKTWIDTH] <= nxt_data[o*PKTWIDTH +: PKTWIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/router_router_mesh.sv
// router_router_mesh: ROWS x COLS mesh of mesh_router nodes r<y><x>,
// r00 at the north-west corner. Flits are injected only at r00's Local
// input and ejected at every node's Local output.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   r00_datain_pein     flit injected at r00 (PKTWIDTH >= 64 for the header)
//   r00_si_pein         injection strobe, one flit per edge
//   pe_dataout          ejected flits, slice n = y*COLS+x
//   pe_so               ejection strobes, bit n = y*COLS+x
module router_router_mesh
  import noc_pkg::*;
#(
  parameter int PKTWIDTH = 64,
  parameter int ROWS     = 4,
  parameter int COLS     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PKTWIDTH-1:0]           r00_datain_pein,
  input  logic                          r00_si_pein,
  output logic [ROWS*COLS*PKTWIDTH-1:0] pe_dataout,
  output logic [ROWS*COLS-1:0]          pe_so
);

  localparam int NODES = ROWS * COLS;

  logic [4:0]            node_in_valid [NODES];
  logic [5*PKTWIDTH-1:0] node_in_data  [NODES];
  logic [4:0]            link_valid    [NODES];
  logic [5*PKTWIDTH-1:0] link_data     [NODES];
  logic                  inj_ok;

  // Out-of-range destinations are dropped here so no router ever has to
  // route off the mesh.
  assign inj_ok = r00_si_pein
               && (32'(r00_datain_pein[DST_X_MSB:DST_X_LSB]) < COLS)
               && (32'(r00_datain_pein[DST_Y_MSB:DST_Y_LSB]) < ROWS);

  for (genvar y = 0; y < ROWS; y++) begin : g_row
    for (genvar x = 0; x < COLS; x++) begin : g_col
      localparam int NI = y * COLS + x;

      logic                v_l, v_n, v_e, v_s, v_w;
      logic [PKTWIDTH-1:0] d_l, d_n, d_e, d_s, d_w;

      if (NI == 0) begin : g_local
        assign v_l = inj_ok;
        assign d_l = r00_datain_pein;
      end else begin : g_local_tie
        assign v_l = 1'b0;
        assign d_l = '0;
      end

      // North neighbour's south output feeds this node's N input, etc.
      if (y > 0) begin : g_n
        assign v_n = link_valid[NI-COLS][P_S];
        assign d_n = link_data[NI-COLS][int'(P_S)*PKTWIDTH +: PKTWIDTH];
      end else begin : g_n_tie
        assign v_n = 1'b0;
        assign d_n = '0;
      end

      if (x < COLS-1) begin : g_e
        assign v_e = link_valid[NI+1][P_W];
        assign d_e = link_data[NI+1][int'(P_W)*PKTWIDTH +: PKTWIDTH];
      end else begin : g_e_tie
        assign v_e = 1'b0;
        assign d_e = '0;
      end

      if (y < ROWS-1) begin : g_s
        assign v_s = link_valid[NI+COLS][P_N];
        assign d_s = link_data[NI+COLS][int'(P_N)*PKTWIDTH +: PKTWIDTH];
      end else begin : g_s_tie
        assign v_s = 1'b0;
        assign d_s = '0;
      end

      if (x > 0) begin : g_w
        assign v_w = link_valid[NI-1][P_E];
        assign d_w = link_data[NI-1][int'(P_E)*PKTWIDTH +: PKTWIDTH];
      end else begin : g_w_tie
        assign v_w = 1'b0;
        assign d_w = '0;
      end

      // Packing order matches the port constants: {W, S, E, N, Local}.
      assign node_in_valid[NI] = {v_w, v_s, v_e, v_n, v_l};
      assign node_in_data[NI]  = {d_w, d_s, d_e, d_n, d_l};

      mesh_router #(
        .PKTWIDTH (PKTWIDTH),
        .X        (x),
        .Y        (y)
      ) u_router (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (node_in_valid[NI]),
        .in_data   (node_in_data[NI]),
        .out_valid (link_valid[NI]),
        .out_data  (link_data[NI])
      );

      assign pe_so[NI] = link_valid[NI][P_LOCAL];
      assign pe_dataout[NI*PKTWIDTH +: PKTWIDTH] =
        link_data[NI][int'(P_LOCAL)*PKTWIDTH +: PKTWIDTH];
    end
  end

endmodule

// File: tb/tb_router_router_mesh.sv
// Self-checking bench for router_router_mesh. The reference model predicts,
// for every accepted injection at edge k, one strobe at node dy*4+dx after
// edge k+dx+dy carrying the unchanged flit.
module tb_router_router_mesh;

  localparam int W    = 64;
  localparam int R    = 4;
  localparam int C    = 4;
  localparam int NN   = R * C;
  localparam int MAXE = 4096;

  logic              clk = 1'b0;
  logic              reset;
  logic [W-1:0]      r00_datain_pein;
  logic              r00_si_pein;
  logic [NN*W-1:0]   pe_dataout;
  logic [NN-1:0]     pe_so;

  int tests  = 0;
  int fails  = 0;
  int edge_no = 0;

  logic [NN-1:0] exp_so [MAXE];
  logic [W-1:0]  exp_d  [MAXE][NN];

  always #5 clk = ~clk;

  router_router_mesh #(.PKTWIDTH(W), .ROWS(R), .COLS(C)) dut (
    .clk             (clk),
    .reset           (reset),
    .r00_datain_pein (r00_datain_pein),
    .r00_si_pein     (r00_si_pein),
    .pe_dataout      (pe_dataout),
    .pe_so           (pe_so)
  );

  task automatic clear_model();
    for (int e = 0; e < MAXE; e++) exp_so[e] = '0;
  endtask

  task automatic predict(input logic [W-1:0] d, input int k);
    int dx = int'(d[63:60]);
    int dy = int'(d[59:56]);
    if (dx < C && dy < R) begin
      exp_so[k+dx+dy][dy*C+dx] = 1'b1;
      exp_d[k+dx+dy][dy*C+dx]  = d;
    end
  endtask

  // Drive one cycle of stimulus; return #1 after the edge.
  task automatic tick(input logic s, input logic [W-1:0] d);
    r00_si_pein     = s;
    r00_datain_pein = d;
    @(posedge clk);
    edge_no++;
    if (s && !reset) predict(d, edge_no);
    #1;
    r00_si_pein     = 1'b0;
    r00_datain_pein = '0;
  endtask

  task automatic test_reset();
    r00_si_pein = 1'b0;
    r00_datain_pein = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    tests++;
    if (pe_so !== '0 || pe_dataout !== '0) begin
      fails++;
      $display("FAIL reset_async: so=%h dout_nonzero=%0d want all zero", pe_so, pe_dataout != '0);
    end
    for (int c = 0; c < 7; c++) begin
      if (c == 2) reset = 1'b0;
      tick(1'b1, 64'h2010DDDDAAAAAAAA & {64{c < 2}});
      tests++;
      if (pe_so !== exp_so[edge_no] || (c < 2 && pe_dataout !== '0)) begin
        fails++;
        $display("FAIL reset_hold edge %0d: so=%h want %h", edge_no, pe_so, exp_so[edge_no]);
      end
    end
  endtask

  task automatic test_single_r02();
    for (int c = 0; c < 8; c++) begin
      tick(c == 0, 64'h2010DDDDAAAAAAAA);
      tests++;
      if (pe_so !== exp_so[edge_no]) begin
        fails++;
        $display("FAIL r02_so edge %0d: got %h want %h", edge_no, pe_so, exp_so[edge_no]);
      end
      for (int n = 0; n < NN; n++) if (exp_so[edge_no][n]) begin
        tests++;
        if (pe_dataout[n*W +: W] !== exp_d[edge_no][n]) begin
          fails++;
          $display("FAIL r02_data node %0d: got %h want %h", n, pe_dataout[n*W +: W], exp_d[edge_no][n]);
        end
      end
    end
  endtask

  task automatic test_far_r33();
    for (int c = 0; c < 10; c++) begin
      tick(c == 0, 64'h3310_0000_1234_5678);
      tests++;
      if (pe_so !== exp_so[edge_no]) begin
        fails++;
        $display("FAIL r33_so edge %0d: got %h want %h", edge_no, pe_so, exp_so[edge_no]);
      end
      for (int n = 0; n < NN; n++) if (exp_so[edge_no][n]) begin
        tests++;
        if (pe_dataout[n*W +: W] !== exp_d[edge_no][n]) begin
          fails++;
          $display("FAIL r33_data node %0d: got %h want %h", n, pe_dataout[n*W +: W], exp_d[edge_no][n]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] flits [3];
    flits[0] = 64'h0001_0000_0000_0A00;
    flits[1] = 64'h1102_0000_0000_0B11;
    flits[2] = 64'h2003_0000_0000_0C02;
    for (int c = 0; c < 9; c++) begin
      tick(c < 3, (c < 3) ? flits[c] : 64'h0);
      tests++;
      if (pe_so !== exp_so[edge_no]) begin
        fails++;
        $display("FAIL b2b_so edge %0d: got %h want %h", edge_no, pe_so, exp_so[edge_no]);
      end
      for (int n = 0; n < NN; n++) if (exp_so[edge_no][n]) begin
        tests++;
        if (pe_dataout[n*W +: W] !== exp_d[edge_no][n]) begin
          fails++;
          $display("FAIL b2b_data node %0d: got %h want %h", n, pe_dataout[n*W +: W], exp_d[edge_no][n]);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    for (int c = 0; c < 22; c++) begin
      tick(c < 2, (c == 0) ? 64'h4000_0000_DEAD_BEEF : 64'h0400_0000_DEAD_BEEF);
      tests++;
      if (pe_so !== '0 || pe_so !== exp_so[edge_no]) begin
        fails++;
        $display("FAIL oor_so edge %0d: got %h want 0", edge_no, pe_so);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    logic         s;
    for (int c = 0; c < 210; c++) begin
      s = (c < 200) && ($urandom_range(0, 3) != 0);
      d = {$urandom(), $urandom()};
      d[63:60] = 4'($urandom_range(0, 4));
      d[59:56] = 4'($urandom_range(0, 4));
      tick(s, d);
      tests++;
      if (pe_so !== exp_so[edge_no]) begin
        fails++;
        $display("FAIL rand_so edge %0d: got %h want %h", edge_no, pe_so, exp_so[edge_no]);
      end
      for (int n = 0; n < NN; n++) if (exp_so[edge_no][n]) begin
        tests++;
        if (pe_dataout[n*W +: W] !== exp_d[edge_no][n]) begin
          fails++;
          $display("FAIL rand_data edge %0d node %0d: got %h want %h", edge_no, n, pe_dataout[n*W +: W], exp_d[edge_no][n]);
        end
      end
    end
  endtask

  task automatic test_midflight_reset();
    for (int c = 0; c < 4; c++) begin
      tick(c == 0, 64'h3320_0000_5555_AAAA);
      tests++;
      if (pe_so !== exp_so[edge_no]) begin
        fails++;
        $display("FAIL mid_pre_so edge %0d: got %h want %h", edge_no, pe_so, exp_so[edge_no]);
      end
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (pe_so !== '0 || pe_dataout !== '0) begin
      fails++;
      $display("FAIL mid_reset_async: so=%h dout_nonzero=%0d want all zero", pe_so, pe_dataout != '0);
    end
    clear_model();
    for (int c = 0; c < 12; c++) begin
      if (c == 2) reset = 1'b0;
      tick(1'b0, 64'h0);
      tests++;
      if (pe_so !== '0 || pe_so !== exp_so[edge_no]) begin
        fails++;
        $display("FAIL mid_after_so edge %0d: got %h want 0", edge_no, pe_so);
      end
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_single_r02();
    test_far_r33();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_midflight_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
